// File: rtl/conv2_adder_sequencer.sv
// conv2_adder_sequencer: walks one frame of output positions through the
// gated adder tree of conv layer 2, checks retirements, flags frame done.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, abort      frame begin request / synchronous cancel (abort wins)
//   in_valid          stage-0 products present this cycle
//   stage_done_last   done output of the final adder stage
//   stage_en          per-stage enables, bit k -> stage k
//   in_ready          accepting in_valid (RUN)
//   out_valid         final-stage result valid, out_index its position
//   busy              high in RUN and DRAIN
//   frame_done        one-cycle completion pulse
//   err               sticky retirement-mismatch flag
module conv2_adder_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int NUM_OUTPUTS = 100,
  parameter int CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic                  stage_done_last,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [CNT_W-1:0]      out_index,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W:0] NOUT =
    (CNT_W+1)'(NUM_OUTPUTS);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      retire_cnt;
  logic [NUM_STAGES-1:1] pipe_q;
  logic                  expect_q;
  logic                  err_q;

  logic           accept;
  logic           start_ok;
  logic           last_issue;
  logic           drained;
  logic [CNT_W:0] issue_nx;
  logic [CNT_W:0] retire_nx;

  assign accept   = (state == RUN) & in_valid & ~abort;
  assign start_ok = (state == IDLE) & start & ~abort;

  assign issue_nx   = {1'b0, issue_cnt} + 1'b1;
  assign last_issue = accept && (issue_nx == NOUT);

  // Look one cycle ahead so DONE follows the last retirement directly:
  // with no enables left, expect_q clears next cycle, and retire_nx
  // already includes a retirement happening now.
  assign retire_nx = {1'b0, retire_cnt}
                   + (CNT_W+1)'(out_valid);
  assign drained   = (pipe_q == '0) && (retire_nx == NOUT);

  assign stage_en   = {pipe_q, accept};
  assign in_ready   = (state == RUN);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign out_valid  = stage_done_last & busy;
  assign out_index  = retire_cnt;
  assign frame_done = (state == DONE);
  assign err        = err_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok)   state_nx = RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (drained)    state_nx = DONE;
      DONE:                    state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pipe_q     <= '0;
      expect_q   <= 1'b0;
      issue_cnt  <= '0;
      retire_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (abort) begin
        pipe_q   <= '0;
        expect_q <= 1'b0;
      end else begin
        pipe_q   <= stage_en[NUM_STAGES-2:0];
        expect_q <= stage_en[NUM_STAGES-1];
      end
      if (abort || start_ok) begin
        issue_cnt  <= '0;
        retire_cnt <= '0;
      end else begin
        if (accept)    issue_cnt  <= issue_cnt + 1'b1;
        if (out_valid) retire_cnt <= retire_cnt + 1'b1;
      end
      // A mismatch in the same cycle as a start still registers.
      err_q <= (err_q & ~start_ok)
             | (stage_done_last != expect_q);
    end
  end

endmodule

// File: tb/tb_conv2_adder_sequencer.sv
// tb_conv2_adder_sequencer: directed bench for conv2_adder_sequencer.
// A registered gated-adder model feeds stage_done_last back.
module tb_conv2_adder_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       stage_done_last;
  logic [2:0] stage_en;
  logic       in_ready;
  logic       out_valid;
  logic [6:0] out_index;
  logic       busy;
  logic       frame_done;
  logic       err;

  logic done_q;
  logic inject;

  int tests;
  int fails;

  conv2_adder_sequencer #(
    .NUM_STAGES (3),
    .NUM_OUTPUTS(100),
    .CNT_W      (7)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .in_valid       (in_valid),
    .stage_done_last(stage_done_last),
    .stage_en       (stage_en),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_index      (out_index),
    .busy           (busy),
    .frame_done     (frame_done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Final gated adder stage: done is its enable, registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= stage_en[2];
  end
  assign stage_done_last = done_q | inject;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame; mode 0 = in_valid always, mode 1 = 1,0,0,1 pattern.
  // spulse = cycle in which a stray start is pulsed (-1: none).
  task automatic run_frame(input int mode, input int spulse);
    int  issued;
    int  retired;
    int  last;
    int  c;
    bit  acc [0:1023];
    bit  ev;
    bit  ov;
    logic [2:0] exp_en;
    issued  = 0;
    retired = 0;
    last    = -100;
    for (int i = 0; i < 1024; i++) acc[i] = 1'b0;
    start    = 1'b1;
    in_valid = 1'b0;
    abort    = 1'b0;
    #1;
    chk("start_cycle_busy", busy, 0);
    tick();
    start = 1'b0;
    c = 0;
    while (c < 1000) begin
      ev = (issued < 100) &&
           (mode == 0 || c % 4 == 0 || c % 4 == 3);
      in_valid = ev;
      start    = (c == spulse);
      acc[c]   = ev;
      #1;
      exp_en[0] = acc[c];
      exp_en[1] = (c >= 1) && acc[c-1];
      exp_en[2] = (c >= 2) && acc[c-2];
      ov = (c >= 3) && acc[c-3];
      chk("in_ready", in_ready, issued < 100);
      chk("stage_en", stage_en, exp_en);
      chk("out_valid", out_valid, ov);
      if (ov) chk("out_index", out_index, retired);
      chk("busy", busy, last < 0 || c <= last + 3);
      chk("frame_done", frame_done,
          last >= 0 && c == last + 4);
      chk("err_clean", err, 0);
      if (ev) begin
        issued++;
        if (issued == 100) last = c;
      end
      if (ov) retired++;
      if (last >= 0 && c == last + 5) break;
      tick();
      c++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("frame_retired", retired, 100);
    chk("frame_end", c, last + 5);
  endtask

  bit saw_done;

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    inject   = 1'b0;
    #12;
    chk("rst_stage_en", stage_en, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Continuous issue, then gapped issue with a stray start mid-RUN.
    run_frame(0, -1);
    tick();
    run_frame(1, 20);
    tick();

    // Mismatch while idle: err next cycle, sticky, cleared by start.
    inject = 1'b1;
    #1;
    chk("inj_err_before", err, 0);
    chk("inj_idle_no_out", out_valid, 0);
    tick();
    inject = 1'b0;
    chk("inj_err_set", err, 1);
    repeat (3) tick();
    chk("inj_err_held", err, 1);
    run_frame(1, -1);
    tick();

    // Spurious retirement mid-frame: count overshoots, DRAIN holds.
    start = 1'b1;
    tick();
    start    = 1'b0;
    inject   = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("spur_out_valid", out_valid, 1);
    chk("spur_out_index", out_index, 0);
    tick();
    inject = 1'b0;
    chk("spur_err", err, 1);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_done |= frame_done;
    end
    chk("spur_stuck_busy", busy, 1);
    chk("spur_no_ready", in_ready, 0);
    chk("spur_no_done", saw_done, 0);
    chk("spur_err_held", err, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("spur_abort_busy", busy, 0);
    chk("spur_abort_err", err, 1);
    tick();
    run_frame(0, -1);
    tick();

    // Abort after 40 accepts.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      tick();
    end
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_stage_en", stage_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    tick();
    chk("abort_inflight_err", err, 1);
    saw_done = frame_done;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw_done |= frame_done;
    end
    chk("abort_no_done", saw_done, 0);
    run_frame(0, -1);
    tick();

    // start+abort mid-RUN, then start+abort in IDLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      tick();
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("sa_run_busy", busy, 0);
    chk("sa_run_ready", in_ready, 0);
    tick();
    chk("sa_idle_busy", busy, 0);
    chk("sa_idle_ready", in_ready, 0);
    start = 1'b0;
    abort = 1'b0;
    repeat (4) tick();

    // Asynchronous reset pulse mid-RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_stage_en", stage_en, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_index", out_index, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    in_valid = 1'b0;
    #9;
    rst_n = 1'b1;
    tick();
    chk("arst_err_after", err, 0);
    chk("arst_busy_after", busy, 0);
    run_frame(0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
